fft_frame_sched: RTL and testbench



---
 rtl/fft_frame_sched.sv | 134 +++++++++++++
 tb/tb_fft_frame_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sched.sv
// Round-robin frame scheduler sharing one pipelined FFT between sources A and B.
// Each FFT output frame is tagged with its source channel through a small tag FIFO.
module fft_frame_sched #(
  parameter int IWIDTH  = 12,
  parameter int OWIDTH  = 16,
  parameter int LGWIDTH = 10,
  parameter int LGTAGS  = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_a_valid,
  output logic                o_a_ready,
  input  logic [2*IWIDTH-1:0] i_a_sample,
  input  logic                i_b_valid,
  output logic                o_b_ready,
  input  logic [2*IWIDTH-1:0] i_b_sample,
  output logic                o_fft_ce,
  output logic [2*IWIDTH-1:0] o_fft_sample,
  input  logic [2*OWIDTH-1:0] i_fft_result,
  input  logic                i_fft_sync,
  output logic                o_valid,
  output logic [2*OWIDTH-1:0] o_result,
  output logic                o_sync,
  output logic                o_chan,
  output logic                o_err
);
  localparam int unsigned DEPTH = 1 << LGTAGS;

  typedef enum logic [1:0] {IDLE, RUN_A, RUN_B} state_t;

  state_t              r_state;
  logic                r_last_grant;
  logic [LGWIDTH-1:0]  r_count;
  logic [DEPTH-1:0]    r_tags;
  logic [LGTAGS-1:0]   r_wptr;
  logic [LGTAGS-1:0]   r_rptr;
  logic [LGTAGS:0]     r_fill;
  logic                r_fft_ce_d;
  logic                r_active;

  logic                w_accept;
  logic                w_last;
  logic [2*IWIDTH-1:0] w_sample;
  logic                w_full;
  logic                w_empty;
  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_push;
  logic                w_qsync;
  logic                w_pop;
  logic                w_out;

  assign o_a_ready = (r_state == RUN_A);
  assign o_b_ready = (r_state == RUN_B);
  assign w_accept  = (o_a_ready & i_a_valid) | (o_b_ready & i_b_valid);
  assign w_sample  = o_b_ready ? i_b_sample : i_a_sample;
  assign w_last    = (r_count == '1);

  // Fill never exceeds DEPTH, so its top bit alone marks a full FIFO.
  assign w_full    = r_fill[LGTAGS];
  assign w_empty   = (r_fill == '0);
  assign w_grant_a = (r_state == IDLE) & ~w_full & i_a_valid & (r_last_grant | ~i_b_valid);
  assign w_grant_b = (r_state == IDLE) & ~w_full & ~w_grant_a & i_b_valid
                     & (~r_last_grant | ~i_a_valid);
  assign w_push    = w_grant_a | w_grant_b;

  assign w_qsync   = r_fft_ce_d & i_fft_sync;
  assign w_pop     = w_qsync & ~w_empty;
  assign w_out     = r_fft_ce_d & (r_active | w_qsync);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_count      <= '0;
      r_tags       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_fill       <= '0;
      r_fft_ce_d   <= 1'b0;
      r_active     <= 1'b0;
      o_fft_ce     <= 1'b0;
      o_fft_sample <= '0;
      o_valid      <= 1'b0;
      o_result     <= '0;
      o_sync       <= 1'b0;
      o_chan       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      // The FFT only advances on accepted samples; stalls freeze it.
      o_fft_ce <= w_accept;
      if (w_accept) begin
        o_fft_sample <= w_sample;
        r_count      <= r_count + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_grant_a)      r_state <= RUN_A;
          else if (w_grant_b) r_state <= RUN_B;
        end
        RUN_A, RUN_B: begin
          if (w_accept && w_last) begin
            r_state      <= IDLE;
            r_last_grant <= (r_state == RUN_B);
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_push) begin
        r_tags[r_wptr] <= w_grant_b;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr   <= r_rptr + 1'b1;
        o_chan   <= r_tags[r_rptr];
        r_active <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase

      r_fft_ce_d <= o_fft_ce;
      o_sync     <= w_pop;
      o_valid    <= w_out;
      if (w_out) o_result <= i_fft_result;
      if (w_qsync && w_empty) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Cycle-level bench for fft_frame_sched: a reference scheduler model plus an ideal
// zero-latency FFT stand-in, with sample and output scoreboards.
module tb_fft_frame_sched;
  localparam int IW    = 12;
  localparam int OW    = 16;
  localparam int LGW   = 3;
  localparam int LGT   = 1;
  localparam int DEPTH = 1 << LGT;
  localparam int FRAME = 1 << LGW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            a_valid = 1'b0;
  logic            b_valid = 1'b0;
  logic [2*IW-1:0] a_sample = '0;
  logic [2*IW-1:0] b_sample = '0;
  logic [2*OW-1:0] fft_result = '0;
  logic            fft_sync = 1'b0;

  logic            a_ready, b_ready, fft_ce, o_valid, o_sync, o_chan, o_err;
  logic [2*IW-1:0] fft_sample;
  logic [2*OW-1:0] o_result;

  fft_frame_sched #(.IWIDTH(IW), .OWIDTH(OW), .LGWIDTH(LGW), .LGTAGS(LGT)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_a_valid    (a_valid),
    .o_a_ready    (a_ready),
    .i_a_sample   (a_sample),
    .i_b_valid    (b_valid),
    .o_b_ready    (b_ready),
    .i_b_sample   (b_sample),
    .o_fft_ce     (fft_ce),
    .o_fft_sample (fft_sample),
    .i_fft_result (fft_result),
    .i_fft_sync   (fft_sync),
    .o_valid      (o_valid),
    .o_result     (o_result),
    .o_sync       (o_sync),
    .o_chan       (o_chan),
    .o_err        (o_err)
  );

  typedef struct {
    logic [2*OW-1:0] res;
    logic            sync;
    logic            chan;
  } out_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state (0=IDLE, 1=RUN_A, 2=RUN_B)
  int              m_state, m_cnt, fft_idx, cyc;
  bit              m_last, m_ce, m_ce_d, m_active, m_chan, m_err, exp_valid;
  bit              tags[$];
  logic [2*IW-1:0] sq[$];
  out_t            rq[$];

  int a_mode = 0, b_mode = 0, sync_mode = 1;
  bit force_rst = 1'b1;

  function automatic logic gen(input int mode);
    case (mode)
      1:       return 1'b1;
      2:       return (cyc % 2) == 0;
      3:       return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_last = 1'b1;
    m_ce = 1'b0; m_ce_d = 1'b0; m_active = 1'b0; m_chan = 1'b0; m_err = 1'b0;
    exp_valid = 1'b0; fft_idx = 0; fft_sync = 1'b0;
    tags.delete(); sq.delete(); rq.delete();
  endtask

  task automatic cycle();
    bit   acc_a, acc_b, qsync, pop, full;
    out_t e;
    logic [2*IW-1:0] s;
    a_valid  = gen(a_mode);
    b_valid  = gen(b_mode);
    a_sample = 24'($urandom);
    b_sample = 24'($urandom);
    rst      = force_rst;
    // Ideal FFT: presents a new output the cycle after each clock enable, else frozen.
    if (m_ce_d) begin
      fft_result = $urandom;
      case (sync_mode)
        0:       fft_sync = 1'b0;
        1:       fft_sync = (fft_idx % FRAME) == 0;
        2:       fft_sync = (fft_idx == 2*FRAME-1);
        default: fft_sync = 1'b1;
      endcase
      fft_idx++;
    end
    if (rst) begin
      model_reset();
    end else begin
      acc_a = (m_state == 1) && a_valid;
      acc_b = (m_state == 2) && b_valid;
      if (acc_a) sq.push_back(a_sample);
      if (acc_b) sq.push_back(b_sample);
      qsync = m_ce_d && fft_sync;
      full  = (tags.size() == DEPTH);
      pop   = qsync && (tags.size() != 0);
      if (qsync && !pop) m_err = 1'b1;
      if (pop) begin
        m_chan   = tags.pop_front();
        m_active = 1'b1;
      end
      exp_valid = m_ce_d && (m_active || qsync);
      if (exp_valid) begin
        e.res = fft_result; e.sync = pop; e.chan = m_chan;
        rq.push_back(e);
      end
      m_ce_d = m_ce;
      m_ce   = acc_a || acc_b;
      if (m_state == 0) begin
        if (!full && a_valid && (m_last || !b_valid)) begin
          m_state = 1; tags.push_back(1'b0);
        end else if (!full && b_valid && (!m_last || !a_valid)) begin
          m_state = 2; tags.push_back(1'b1);
        end
      end else if (acc_a || acc_b) begin
        if (m_cnt == FRAME-1) begin
          m_last = (m_state == 2); m_state = 0; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end

    @(posedge clk);
    #1;
    cyc++;

    check("a_ready", 64'(a_ready), 64'(m_state == 1));
    check("b_ready", 64'(b_ready), 64'(m_state == 2));
    check("fft_ce", 64'(fft_ce), 64'(m_ce));
    if (fft_ce) begin
      if (sq.size() == 0) check("fft_ce_extra", 64'(fft_ce), 64'(0));
      else begin
        s = sq.pop_front();
        check("fft_sample", 64'(fft_sample), 64'(s));
      end
    end
    check("valid", 64'(o_valid), 64'(exp_valid));
    if (o_valid || exp_valid) begin
      if (rq.size() == 0) check("valid_extra", 64'(o_valid), 64'(0));
      else begin
        e = rq.pop_front();
        if (o_valid) begin
          check("result", 64'(o_result), 64'(e.res));
          check("sync", 64'(o_sync), 64'(e.sync));
          check("chan", 64'(o_chan), 64'(e.chan));
        end
      end
    end else begin
      check("sync_idle", 64'(o_sync), 64'(0));
    end
    check("err", 64'(o_err), 64'(m_err));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic zero_check();
    check("rst_a_ready", 64'(a_ready), 64'(0));
    check("rst_b_ready", 64'(b_ready), 64'(0));
    check("rst_fft_ce", 64'(fft_ce), 64'(0));
    check("rst_fft_sample", 64'(fft_sample), 64'(0));
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_result", 64'(o_result), 64'(0));
    check("rst_sync", 64'(o_sync), 64'(0));
    check("rst_chan", 64'(o_chan), 64'(0));
    check("rst_err", 64'(o_err), 64'(0));
  endtask

  task automatic reset_pulse();
    force_rst = 1'b1;
    run(2);
    zero_check();
    force_rst = 1'b0;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    force_rst = 1'b1;
    run(3);
    zero_check();
    force_rst = 1'b0;

    // A alone: repeated grants to A with one arbitration cycle between frames
    a_mode = 1; run(3*(FRAME+1) + 4);
    // A and B both continuous: alternating frames
    b_mode = 1; run(4*(FRAME+1) + 4);
    // B toggling alone: frames stretch to twice their length
    a_mode = 0; b_mode = 2; run(4*FRAME + 6);
    b_mode = 0; run(4);

    // Tag FIFO full: two frames without syncs, late sync on the second releases a grant
    reset_pulse();
    sync_mode = 2; a_mode = 1; run(4*(FRAME+1) + 6);
    a_mode = 0; run(4);

    // Sync with empty FIFO sets sticky error; then reset mid-frame
    reset_pulse();
    sync_mode = 3; a_mode = 1; run(FRAME + 4);
    for (int i = 0; i < 40 && !(m_state != 0 && m_cnt == 5); i++) run(1);
    force_rst = 1'b1;
    run(1);
    zero_check();
    force_rst = 1'b0;
    sync_mode = 1; run(2*(FRAME+1) + 4);

    // Random contention
    a_mode = 3; b_mode = 3; run(300);
    a_mode = 0; b_mode = 0; run(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
